// File: rtl/mseq_checker.sv
// Serial m-sequence receiver and bit-error checker for o[k] = o[k-1] ^ o[k-4].
// Optional macro MSEQ_CHK_FLYWHEEL_EN: in LOCK the replica free-runs on its own prediction.
module mseq_checker #(
  parameter int LOCK_CNT = 15,
  parameter int LOSS_THR = 3,
  parameter int ERR_W    = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic [1:0]       state,
  output logic             bit_err,
  output logic             sync_loss,
  output logic [ERR_W-1:0] bit_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  localparam logic [5:0]       LOCK_CNT_V = 6'(LOCK_CNT);
  localparam logic [3:0]       LOSS_THR_V = 4'(LOSS_THR);
  localparam logic [ERR_W-1:0] CNT_MAX    = '1;
  localparam logic [ERR_W-1:0] CNT_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [3:0]       hist_reg, hist_next;
  logic [2:0]       fill_reg, fill_next;
  logic [5:0]       match_reg, match_next;
  logic [3:0]       win_cnt_reg, win_cnt_next;
  logic [3:0]       win_err_reg, win_err_next;
  logic             locked_reg, bit_err_reg, bit_err_next;
  logic             sync_loss_reg, sync_loss_next;
  logic [ERR_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

  logic       pred, mis, lock_bit;
  logic [3:0] win_err_inc;
  logic [5:0] match_inc;

  assign pred        = hist_reg[3] ^ hist_reg[0];
  assign mis         = rx_valid & (rx_bit != pred);
  assign win_err_inc = win_err_reg + {3'b000, mis};
  assign match_inc   = match_reg + 6'd1;

`ifdef MSEQ_CHK_FLYWHEEL_EN
  assign lock_bit = pred;
`else
  assign lock_bit = rx_bit;
`endif

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    state_next     = state_reg;
    hist_next      = hist_reg;
    fill_next      = fill_reg;
    match_next     = match_reg;
    win_cnt_next   = win_cnt_reg;
    win_err_next   = win_err_reg;
    bit_err_next   = 1'b0;
    sync_loss_next = 1'b0;
    bit_cnt_next   = bit_cnt_reg;
    err_cnt_next   = err_cnt_reg;

    if (rx_valid) begin
      case (state_reg)
        ST_SEARCH: begin
          hist_next = {hist_reg[2:0], rx_bit};
          fill_next = fill_reg + 3'd1;
          if (fill_reg == 3'd3) begin
            state_next = ST_VERIFY;
            match_next = 6'd0;
          end
        end
        ST_VERIFY: begin
          hist_next = {hist_reg[2:0], rx_bit};
          // An all-zero history predicts zeros forever, so it never earns credit.
          if (!mis && (hist_reg != 4'b0000)) begin
            match_next = match_inc;
            if (match_inc == LOCK_CNT_V) begin
              state_next   = ST_LOCK;
              win_cnt_next = 4'd0;
              win_err_next = 4'd0;
            end
          end else begin
            match_next = 6'd0;
          end
        end
        ST_LOCK: begin
          hist_next    = {hist_reg[2:0], lock_bit};
          bit_cnt_next = sat_inc(bit_cnt_reg);
          if (mis) begin
            bit_err_next = 1'b1;
            err_cnt_next = sat_inc(err_cnt_reg);
          end
          // Threshold wins over the window wrap that may happen on the same bit.
          if (win_err_inc >= LOSS_THR_V) begin
            state_next     = ST_SEARCH;
            sync_loss_next = 1'b1;
            fill_next      = 3'd0;
            win_err_next   = win_err_inc;
          end else if (win_cnt_reg == 4'd14) begin
            win_cnt_next = 4'd0;
            win_err_next = 4'd0;
          end else begin
            win_cnt_next = win_cnt_reg + 4'd1;
            win_err_next = win_err_inc;
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end

    if (clr_cnt) begin
      bit_cnt_next = '0;
      err_cnt_next = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= ST_SEARCH;
      hist_reg      <= 4'd0;
      fill_reg      <= 3'd0;
      match_reg     <= 6'd0;
      win_cnt_reg   <= 4'd0;
      win_err_reg   <= 4'd0;
      locked_reg    <= 1'b0;
      bit_err_reg   <= 1'b0;
      sync_loss_reg <= 1'b0;
      bit_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      hist_reg      <= hist_next;
      fill_reg      <= fill_next;
      match_reg     <= match_next;
      win_cnt_reg   <= win_cnt_next;
      win_err_reg   <= win_err_next;
      locked_reg    <= (state_next == ST_LOCK);
      bit_err_reg   <= bit_err_next;
      sync_loss_reg <= sync_loss_next;
      bit_cnt_reg   <= bit_cnt_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign state     = state_reg;
  assign locked    = locked_reg;
  assign bit_err   = bit_err_reg;
  assign sync_loss = sync_loss_reg;
  assign bit_cnt   = bit_cnt_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_mseq_checker.sv
// Bench for mseq_checker: directed scenarios plus random traffic against a behavioural model.
module tb_mseq_checker;

  localparam int LOCK_CNT = 15;
  localparam int LOSS_THR = 3;
  localparam int ERR_W    = 10;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             rx_bit = 1'b0;
  logic             rx_valid = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             locked;
  logic [1:0]       state;
  logic             bit_err;
  logic             sync_loss;
  logic [ERR_W-1:0] bit_cnt;
  logic [ERR_W-1:0] err_cnt;

  always #5 sys_clk = ~sys_clk;

  mseq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .ERR_W(ERR_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .clr_cnt(clr_cnt), .locked(locked), .state(state), .bit_err(bit_err),
    .sync_loss(sync_loss), .bit_cnt(bit_cnt), .err_cnt(err_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_cmp = 0;
  int t = 0;

  // Source generator: last four emitted bits, newest in gen_q[0].
  logic [3:0] gen_q = 4'b0001;

  task automatic gen_next(output logic b);
    b = gen_q[0] ^ gen_q[3];
    gen_q = {gen_q[2:0], b};
  endtask

  // Reference model: phase (0 search, 1 verify, 2 lock) and its bookkeeping.
  int       m_phase, m_fill, m_match, m_wpos, m_werr, m_bits, m_errs;
  logic [3:0] m_recent;
  logic     m_berr, m_sloss;

  task automatic model_step(input logic rb, input logic rv, input logic cc, input logic rst);
    logic expect_bit;
    logic wrong;
    if (rst) begin
      m_phase = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
      m_bits = 0; m_errs = 0; m_recent = 4'd0; m_berr = 0; m_sloss = 0;
      return;
    end
    m_berr = 0;
    m_sloss = 0;
    if (rv) begin
      expect_bit = m_recent[0] ^ m_recent[3];
      wrong = (rb != expect_bit);
      if (m_phase == 0) begin
        m_recent = {m_recent[2:0], rb};
        m_fill++;
        if (m_fill == 4) begin m_phase = 1; m_match = 0; end
      end else if (m_phase == 1) begin
        if (!wrong && m_recent != 4'd0) m_match++; else m_match = 0;
        m_recent = {m_recent[2:0], rb};
        if (m_match == LOCK_CNT) begin m_phase = 2; m_wpos = 0; m_werr = 0; end
      end else begin
        if (m_bits < CNT_MAX) m_bits++;
        if (wrong) begin
          m_berr = 1;
          if (m_errs < CNT_MAX) m_errs++;
          m_werr++;
        end
`ifdef MSEQ_CHK_FLYWHEEL_EN
        m_recent = {m_recent[2:0], expect_bit};
`else
        m_recent = {m_recent[2:0], rb};
`endif
        if (m_werr >= LOSS_THR) begin
          m_phase = 0; m_sloss = 1; m_fill = 0;
        end else begin
          m_wpos = (m_wpos + 1) % 15;
          if (m_wpos == 0) m_werr = 0;
        end
      end
    end
    if (cc) begin m_bits = 0; m_errs = 0; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %0d want %0d", name, t, act, exp);
    end
  endtask

  task automatic cycle(input logic rb, input logic rv, input logic cc, input logic rst);
    rx_bit = rb; rx_valid = rv; clr_cnt = cc; sys_rst = rst;
    @(posedge sys_clk);
    model_step(rb, rv, cc, rst);
    #1;
    n_vec++;
    t++;
    check("state", 32'(state), 32'(m_phase));
    check("locked", 32'(locked), 32'(m_phase == 2));
    check("bit_err", 32'(bit_err), 32'(m_berr));
    check("sync_loss", 32'(sync_loss), 32'(m_sloss));
    check("bit_cnt", 32'(bit_cnt), 32'(m_bits));
    check("err_cnt", 32'(err_cnt), 32'(m_errs));
  endtask

  task automatic gcyc(input logic flip, input logic cc);
    logic b;
    gen_next(b);
    cycle(b ^ flip, 1'b1, cc, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    t = 0;
  endtask

  initial begin
    int duty;
    logic b, v;

    // Reset values
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    check("rst_state", 32'(state), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_cnts", 32'(bit_cnt) | 32'(err_cnt), 0);

    // Clean continuous stream: lock latency, long run, saturation, clear
    for (int i = 1; i <= 1119; i++) begin
      gcyc(1'b0, 1'b0);
      if (i == 18) check("lock_pre", 32'(locked), 0);
      if (i == 19) check("lock_at_19", 32'(locked), 1);
      if (i == 1019) check("bits_1000", 32'(bit_cnt), 1000);
      if (i == 1019) check("errs_clean", 32'(err_cnt), 0);
      if (i == 1119) check("bits_sat", 32'(bit_cnt), CNT_MAX);
    end
    gcyc(1'b0, 1'b1);
    check("clr_bits", 32'(bit_cnt), 0);

    // Single flips in LOCK, window wrap, clear on an errored bit
    do_reset();
    for (int i = 1; i <= 80; i++) begin
      gcyc((i == 22) || (i == 60), i == 60);
`ifdef MSEQ_CHK_FLYWHEEL_EN
      if (i == 30) check("fly_err1", 32'(err_cnt), 1);
      if (i == 30) check("fly_locked", 32'(locked), 1);
      if (i == 65) check("fly_after_clr", 32'(err_cnt), 0);
`else
      if (i == 26) check("loss_pulse", 32'(sync_loss), 1);
      if (i == 26) check("loss_errs", 32'(err_cnt), 3);
      if (i == 26) check("loss_state", 32'(state), 0);
      if (i == 44) check("relock_pre", 32'(locked), 0);
      if (i == 45) check("relock_45", 32'(locked), 1);
      if (i == 65) check("wrap_errs", 32'(err_cnt), 2);
      if (i == 65) check("wrap_locked", 32'(locked), 1);
`endif
      if (i == 60) check("clr_err_errs", 32'(err_cnt), 0);
      if (i == 60) check("clr_err_bits", 32'(bit_cnt), 0);
      if (i == 60) check("clr_err_pulse", 32'(bit_err), 1);
    end

    // Stuck-at-0 line never locks
    do_reset();
    for (int i = 1; i <= 100; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("stuck_state", 32'(state), 1);
    check("stuck_locked", 32'(locked), 0);
    check("stuck_errs", 32'(err_cnt), 0);

    // Half-rate valid with junk on idle cycles, then errors and reset while locked
    do_reset();
    for (int i = 1; i <= 80; i++) begin
      v = i[0];
      if (v) gen_next(b); else b = 1'($urandom);
      cycle(b ^ (v && (i == 61 || i == 71)), v, 1'b0, 1'b0);
      if (i == 36) check("half_lock_pre", 32'(locked), 0);
      if (i == 37) check("half_lock_37", 32'(locked), 1);
    end
    do_reset();
    check("rst2_state", 32'(state), 0);
    check("rst2_errs", 32'(err_cnt), 0);
    check("rst2_bits", 32'(bit_cnt), 0);
    for (int i = 1; i <= 19; i++) gcyc(1'b0, 1'b0);
    check("rst2_relock", 32'(locked), 1);

    // Random traffic
    duty = 100;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) duty = 25 * (1 + ($urandom % 4));
      v = ($urandom % 100) < duty;
      if (v) gen_next(b); else b = 1'($urandom);
      cycle(b ^ (v && ($urandom % 50 == 0)), v, ($urandom % 150) == 0,
            ($urandom % 700) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
